// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the 5-stage pipeline hazard controller: command-word
// field positions, PCSource and forwarding encodings, scoreboard entry type.
package pipe_ctrl_pkg;

  localparam int SB_AW = 5;

  localparam int CMD_PCS_HI  = 9;
  localparam int CMD_PCS_LO  = 8;
  localparam int CMD_WEN     = 7;
  localparam int CMD_ALUSRCB = 6;
  localparam int CMD_WADDR   = 5;
  localparam int CMD_MEMW    = 4;
  localparam int CMD_WDATA   = 3;

  localparam logic [1:0] PCS_SEQ = 2'd0;
  localparam logic [1:0] PCS_BEQ = 2'd1;
  localparam logic [1:0] PCS_J   = 2'd2;
  localparam logic [1:0] PCS_BNE = 2'd3;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef struct packed {
    logic             valid;
    logic             wen;
    logic             load;
    logic [SB_AW-1:0] dest;
  } sb_entry_t;

endpackage

// File: rtl/pipe_fwd_sel.sv
// Forwarding select for one source register, given the entries that will sit
// in MEM and WB when the consumer reaches EX.
module pipe_fwd_sel
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = SB_AW
) (
  input  logic [REG_AW-1:0] src_i,
  input  sb_entry_t         mem_i,
  input  sb_entry_t         wb_i,
  output logic [1:0]        sel_o
);

  logic memHit;
  logic wbHit;

  // A load heading into MEM is excluded: its consumer is stalled instead.
  always_comb begin
    memHit = mem_i.valid && mem_i.wen && !mem_i.load &&
             (mem_i.dest != '0) && (mem_i.dest == src_i);
    wbHit  = wb_i.valid && wb_i.wen &&
             (wb_i.dest != '0) && (wb_i.dest == src_i);
    if (memHit) begin
      sel_o = FWD_MEM;
    end else if (wbHit) begin
      sel_o = FWD_WB;
    end else begin
      sel_o = FWD_RF;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush/forwarding controller with an EX/MEM shadow scoreboard.
// Optional performance counters are built when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CMD_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [CMD_W-1:0]  id_cmd,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_br_taken,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [15:0]       perf_stalls,
  output logic [15:0]       perf_flushes
);

  // The WB slot is represented by the registered fwd selects, so only the
  // entries in EX and MEM are held as state.
  sb_entry_t   ex_q, ex_d, mem_q;
  logic [1:0]  fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [1:0]  fwdASel, fwdBSel;

  logic [1:0]        pcs;
  logic              useRs, useRt, loadUse, jumpId;
  logic [REG_AW-1:0] idDest;
  logic [2:0]        unusedAluCtl;

  assign unusedAluCtl = id_cmd[2:0];

  always_comb begin
    pcs     = id_cmd[CMD_PCS_HI:CMD_PCS_LO];
    useRs   = (pcs != PCS_J);
    useRt   = !id_cmd[CMD_ALUSRCB] || id_cmd[CMD_MEMW] ||
              (pcs == PCS_BEQ) || (pcs == PCS_BNE);
    idDest  = id_cmd[CMD_WADDR] ? id_rd : id_rt;
    loadUse = id_valid && ex_q.valid && ex_q.wen && ex_q.load &&
              (ex_q.dest != '0) &&
              ((useRs && (id_rs == ex_q.dest)) || (useRt && (id_rt == ex_q.dest)));
    jumpId  = id_valid && (pcs == PCS_J);
  end

  // A taken branch squashes the ID instruction, so it masks stall and jump.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!reset) begin
      if (ex_br_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (loadUse) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_bubble = 1'b1;
      end else if (jumpId) begin
        ifid_flush  = 1'b1;
      end
    end
  end

  pipe_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .src_i (id_rs),
    .mem_i (ex_q),
    .wb_i  (mem_q),
    .sel_o (fwdASel)
  );

  pipe_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .src_i (id_rt),
    .mem_i (ex_q),
    .wb_i  (mem_q),
    .sel_o (fwdBSel)
  );

  always_comb begin
    ex_d    = '0;
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (id_valid && !idex_bubble) begin
      ex_d.valid = 1'b1;
      ex_d.wen   = id_cmd[CMD_WEN];
      ex_d.load  = id_cmd[CMD_WDATA];
      ex_d.dest  = idDest;
      fwd_a_d    = fwdASel;
      fwd_b_d    = fwdBSel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q    <= '0;
      mem_q   <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      mem_q   <= ex_q;
      ex_q    <= ex_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic [15:0] perf_stalls_q, perf_flushes_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stalls_q  <= '0;
      perf_flushes_q <= '0;
    end else begin
      if (pc_stall && (perf_stalls_q != 16'hFFFF)) begin
        perf_stalls_q <= perf_stalls_q + 16'd1;
      end
      if (ifid_flush && (perf_flushes_q != 16'hFFFF)) begin
        perf_flushes_q <= perf_flushes_q + 16'd1;
      end
    end
  end

  assign perf_stalls  = perf_stalls_q;
  assign perf_flushes = perf_flushes_q;
`else
  assign perf_stalls  = '0;
  assign perf_flushes = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; counter checks depend on
// whether PIPE_HAZARD_PERF_EN is defined.
module tb_pipe_hazard_ctrl;

  localparam logic [9:0] CMD_ADD = 10'h0A2;
  localparam logic [9:0] CMD_SUB = 10'h0A6;
  localparam logic [9:0] CMD_OR  = 10'h0A1;
  localparam logic [9:0] CMD_LW  = 10'h0CA;
  localparam logic [9:0] CMD_J   = 10'h240;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        idValid = 1'b0;
  logic [9:0]  idCmd = '0;
  logic [4:0]  idRs = '0, idRt = '0, idRd = '0;
  logic        exBrTaken = 1'b0;
  logic        pcStall, ifidStall, ifidFlush, idexBubble;
  logic [1:0]  fwdA, fwdB;
  logic [15:0] perfStalls, perfFlushes;

  int checkCount = 0;
  int errorCount = 0;

  pipe_hazard_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (idValid),
    .id_cmd       (idCmd),
    .id_rs        (idRs),
    .id_rt        (idRt),
    .id_rd        (idRd),
    .ex_br_taken  (exBrTaken),
    .pc_stall     (pcStall),
    .ifid_stall   (ifidStall),
    .ifid_flush   (ifidFlush),
    .idex_bubble  (idexBubble),
    .fwd_a        (fwdA),
    .fwd_b        (fwdB),
    .perf_stalls  (perfStalls),
    .perf_flushes (perfFlushes)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [9:0] c, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd, input logic br);
    idValid = v; idCmd = c; idRs = rs; idRt = rt; idRd = rd; exBrTaken = br;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drainPipe();
    applyStimulus(1'b0, '0, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (3) nextCycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(1'b0, '0, 5'd0, 5'd0, 5'd0, 1'b0);
    nextCycle();
    nextCycle();
    reset = 1'b0;
    #1;
    checkCount++;
    if ({pcStall, ifidStall, ifidFlush, idexBubble} !== 4'b0000) begin
      errorCount++;
      $display("[TB] FAIL reset_ctl: got %b expected 0000", {pcStall, ifidStall, ifidFlush, idexBubble});
    end
    checkCount++;
    if ({fwdA, fwdB} !== 4'b0000) begin
      errorCount++;
      $display("[TB] FAIL reset_fwd: got %b expected 0000", {fwdA, fwdB});
    end
    checkCount++;
    if ({perfStalls, perfFlushes} !== 32'h0) begin
      errorCount++;
      $display("[TB] FAIL reset_perf: got %h expected 0", {perfStalls, perfFlushes});
    end
  endtask

  task automatic test_load_use();
    drainPipe();
    applyStimulus(1'b1, CMD_LW, 5'd0, 5'd2, 5'd0, 1'b0);
    checkCount++;
    if (pcStall !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL lu_no_early_stall: got %b expected 0", pcStall);
    end
    nextCycle();
    applyStimulus(1'b1, CMD_ADD, 5'd2, 5'd4, 5'd3, 1'b0);
    checkCount++;
    if ({pcStall, ifidStall, idexBubble, ifidFlush} !== 4'b1110) begin
      errorCount++;
      $display("[TB] FAIL lu_stall: got %b expected 1110", {pcStall, ifidStall, idexBubble, ifidFlush});
    end
    nextCycle();
    checkCount++;
    if ({pcStall, idexBubble, fwdA} !== 4'b0000) begin
      errorCount++;
      $display("[TB] FAIL lu_one_cycle: got %b expected 0000", {pcStall, idexBubble, fwdA});
    end
    nextCycle();
    checkCount++;
    if ({fwdA, fwdB} !== 4'b1000) begin
      errorCount++;
      $display("[TB] FAIL lu_fwd_wb: got %b expected 1000", {fwdA, fwdB});
    end
  endtask

  task automatic test_fwd_mem();
    drainPipe();
    applyStimulus(1'b1, CMD_ADD, 5'd1, 5'd1, 5'd5, 1'b0);
    nextCycle();
    applyStimulus(1'b1, CMD_SUB, 5'd5, 5'd5, 5'd6, 1'b0);
    checkCount++;
    if ({pcStall, idexBubble} !== 2'b00) begin
      errorCount++;
      $display("[TB] FAIL alu_no_stall: got %b expected 00", {pcStall, idexBubble});
    end
    nextCycle();
    checkCount++;
    if ({fwdA, fwdB} !== 4'b0101) begin
      errorCount++;
      $display("[TB] FAIL alu_fwd_mem: got %b expected 0101", {fwdA, fwdB});
    end
  endtask

  task automatic test_fwd_wb_and_zero();
    drainPipe();
    applyStimulus(1'b1, CMD_ADD, 5'd1, 5'd1, 5'd5, 1'b0);
    nextCycle();
    applyStimulus(1'b0, '0, 5'd0, 5'd0, 5'd0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, CMD_OR, 5'd5, 5'd0, 5'd7, 1'b0);
    nextCycle();
    checkCount++;
    if ({fwdA, fwdB} !== 4'b1000) begin
      errorCount++;
      $display("[TB] FAIL wb_fwd: got %b expected 1000", {fwdA, fwdB});
    end
    applyStimulus(1'b1, CMD_LW, 5'd0, 5'd0, 5'd0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, CMD_ADD, 5'd0, 5'd0, 5'd0, 1'b0);
    checkCount++;
    if ({pcStall, idexBubble} !== 2'b00) begin
      errorCount++;
      $display("[TB] FAIL r0_no_stall: got %b expected 00", {pcStall, idexBubble});
    end
    nextCycle();
    applyStimulus(1'b1, CMD_ADD, 5'd0, 5'd0, 5'd8, 1'b0);
    nextCycle();
    checkCount++;
    if ({fwdA, fwdB} !== 4'b0000) begin
      errorCount++;
      $display("[TB] FAIL r0_no_fwd: got %b expected 0000", {fwdA, fwdB});
    end
  endtask

  task automatic test_branch();
    drainPipe();
    applyStimulus(1'b1, CMD_LW, 5'd0, 5'd2, 5'd0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, CMD_ADD, 5'd2, 5'd4, 5'd3, 1'b1);
    checkCount++;
    if ({ifidFlush, idexBubble, pcStall, ifidStall} !== 4'b1100) begin
      errorCount++;
      $display("[TB] FAIL br_flush: got %b expected 1100", {ifidFlush, idexBubble, pcStall, ifidStall});
    end
    nextCycle();
    applyStimulus(1'b1, CMD_ADD, 5'd2, 5'd4, 5'd3, 1'b0);
    checkCount++;
    if ({pcStall, ifidFlush, fwdA} !== 4'b0000) begin
      errorCount++;
      $display("[TB] FAIL br_after: got %b expected 0000", {pcStall, ifidFlush, fwdA});
    end
  endtask

  task automatic test_jump();
    drainPipe();
    applyStimulus(1'b1, CMD_J, 5'd0, 5'd0, 5'd0, 1'b0);
    checkCount++;
    if ({ifidFlush, pcStall, idexBubble} !== 3'b100) begin
      errorCount++;
      $display("[TB] FAIL j_flush: got %b expected 100", {ifidFlush, pcStall, idexBubble});
    end
    nextCycle();
    applyStimulus(1'b0, CMD_J, 5'd0, 5'd0, 5'd0, 1'b0);
    checkCount++;
    if (ifidFlush !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL j_one_cycle: got %b expected 0", ifidFlush);
    end
    nextCycle();
    applyStimulus(1'b1, CMD_J, 5'd0, 5'd0, 5'd0, 1'b1);
    checkCount++;
    if ({ifidFlush, idexBubble, pcStall} !== 3'b110) begin
      errorCount++;
      $display("[TB] FAIL j_vs_branch: got %b expected 110", {ifidFlush, idexBubble, pcStall});
    end
    nextCycle();
  endtask

  task automatic test_reset_mid_stall();
    drainPipe();
    applyStimulus(1'b1, CMD_LW, 5'd0, 5'd2, 5'd0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, CMD_ADD, 5'd2, 5'd4, 5'd3, 1'b0);
    checkCount++;
    if (pcStall !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL rst_pre_stall: got %b expected 1", pcStall);
    end
    reset = 1'b1;
    #1;
    checkCount++;
    if ({pcStall, idexBubble} !== 2'b00) begin
      errorCount++;
      $display("[TB] FAIL rst_priority: got %b expected 00", {pcStall, idexBubble});
    end
    nextCycle();
    reset = 1'b0;
    #1;
    checkCount++;
    if ({pcStall, ifidStall, idexBubble, fwdA, fwdB} !== 7'b0) begin
      errorCount++;
      $display("[TB] FAIL rst_cleared: got %b expected 0000000", {pcStall, ifidStall, idexBubble, fwdA, fwdB});
    end
    nextCycle();
    checkCount++;
    if (fwdA !== 2'd0) begin
      errorCount++;
      $display("[TB] FAIL rst_sb_empty: got %0d expected 0", fwdA);
    end
    checkCount++;
    if (perfStalls !== 16'h0) begin
      errorCount++;
      $display("[TB] FAIL rst_perf_clr: got %h expected 0", perfStalls);
    end
  endtask

  task automatic test_perf();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, CMD_LW, 5'd0, 5'd2, 5'd0, 1'b0);
      nextCycle();
      applyStimulus(1'b1, CMD_ADD, 5'd2, 5'd4, 5'd3, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, '0, 5'd0, 5'd0, 5'd0, 1'b1);
    nextCycle();
    nextCycle();
    applyStimulus(1'b0, '0, 5'd0, 5'd0, 5'd0, 1'b0);
`ifdef PIPE_HAZARD_PERF_EN
    checkCount++;
    if ({perfStalls, perfFlushes} !== {16'd3, 16'd2}) begin
      errorCount++;
      $display("[TB] FAIL perf_count: got %0d/%0d expected 3/2", perfStalls, perfFlushes);
    end
    applyStimulus(1'b0, '0, 5'd0, 5'd0, 5'd0, 1'b1);
    repeat (65540) @(posedge clk);
    #1;
    checkCount++;
    if ({perfStalls, perfFlushes} !== {16'd3, 16'hFFFF}) begin
      errorCount++;
      $display("[TB] FAIL perf_saturate: got %h/%h expected 0003/ffff", perfStalls, perfFlushes);
    end
    applyStimulus(1'b0, '0, 5'd0, 5'd0, 5'd0, 1'b0);
`else
    checkCount++;
    if ({perfStalls, perfFlushes} !== 32'h0) begin
      errorCount++;
      $display("[TB] FAIL perf_disabled: got %h expected 0", {perfStalls, perfFlushes});
    end
`endif
  endtask

  initial begin
    $display("[TB] starting pipe_hazard_ctrl bench");
    test_reset();
    test_load_use();
    test_fwd_mem();
    test_fwd_wb_and_zero();
    test_branch();
    test_jump();
    test_reset_mid_stall();
    test_perf();
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage MIPS core (IF, ID, EX, MEM, WB).
- Consumes the 10-bit decoded command word plus register fields of the instruction in ID.
- Keeps a shadow scoreboard of in-flight destination registers for EX, MEM and WB.
- Drives PC/IF-ID stalls, bubbles, flushes and registered EX forwarding selects.

Parameters:
- REG_AW, 5, register address width.
- CMD_W, 10, command word width.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_cmd  in  CMD_W  command word. Fields: [9:8] PCSource (0 seq, 1 beq, 2 j, 3 bne), [7] WriteEnable, [6] ALUSrcB, [5] WriteAddr (1=rd, 0=rt), [4] MemWrite, [3] WriteData (1=load), [2:0] ALUControl
- id_rs, id_rt, id_rd  in  REG_AW each  register fields of the ID instruction
- ex_br_taken  in  1  branch in EX resolved taken (EX compare result)
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID register
- ifid_flush  out  1  zero IF/ID next edge
- idex_bubble  out  1  load a NOP into ID/EX next edge
- fwd_a, fwd_b  out  2 each  registered operand select for the EX instruction: 0 regfile, 1 MEM result, 2 WB result
- perf_stalls, perf_flushes  out  16 each  counters (see Optional Feature)

Behaviour:
- Reset:
  - All outputs 0.
  - EX/MEM/WB scoreboard entries {valid, wen, load, dest} cleared.
  - Reset asserted mid-stall or mid-flush takes priority and clears everything on the same edge.
- Source and destination decode:
  - dest = WriteAddr ? rd : rt.
  - rs is used unless PCSource==2.
  - rt is used if ALUSrcB==0, or MemWrite, or PCSource is 1 or 3.
  - Register 0 never matches for hazard detection or forwarding.
- Load-use hazard:
  - Condition: EX.valid & EX.wen & EX.load & EX.dest!=0 & (EX.dest matches a used source of ID) & id_valid.
  - Action: pc_stall=ifid_stall=idex_bubble=1 combinationally, for exactly one cycle.
  - On the next cycle the load sits in MEM, not EX, so the hazard clears by construction.
- Branch:
  - ex_br_taken=1 gives ifid_flush=1 and idex_bubble=1 in the same cycle.
  - Flush penalty is 2 instructions.
- Jump:
  - id_valid & PCSource==2 gives ifid_flush=1 for 1 cycle (1-instruction penalty).
  - PC is not stalled.
- Priority: reset > ex_br_taken > load-use stall > jump.
  - A taken branch suppresses the stall and the ID jump, because the ID instruction is squashed.
  - Stall and flush are never both asserted.
- Scoreboard shift each edge:
  - WB <= MEM; MEM <= EX.
  - EX <= ID info, or invalid when idex_bubble or !id_valid.
  - Stalls do not freeze EX/MEM/WB.
- Forwarding, computed from ID sources against the next-cycle MEM/WB entries and registered alongside the EX entry:
  - fwd_a=1 if the current EX entry (becoming MEM) has wen and dest==rs.
  - Otherwise fwd_a=2 if the current MEM entry (becoming WB) matches.
  - Otherwise 0. MEM priority over WB. Same rules for fwd_b with rt.
  - A bubble registers 0.
  - A load in MEM is never selected by fwd; it is covered by the stall.
- Latency: hazard outputs are combinational from the current state plus ID inputs. fwd_* has 1-cycle latency, aligned with the EX stage.

Optional Feature:
- PIPE_HAZARD_PERF_EN defined:
  - perf_stalls increments on each load-use stall cycle.
  - perf_flushes increments on each cycle with ifid_flush.
  - Both are 16-bit, saturate at 16'hFFFF and clear on reset.
- Not defined: both ports are constant 0 and no counter flops are built.

Decomposition:
- Package pipe_ctrl_pkg:
  - Command-field index constants.
  - PCSource encodings PCS_SEQ/PCS_BEQ/PCS_J/PCS_BNE.
  - FWD_RF/FWD_MEM/FWD_WB.
  - Scoreboard entry struct typedef.
- Sub-module pipe_fwd_sel: combinational compare of one source register against two scoreboard entries, returning a 2-bit select. Instantiated twice (A, B).

Test Plan:
- lw $2 then add $3,$2,$4 back-to-back -> one cycle with pc_stall=ifid_stall=idex_bubble=1; two cycles later fwd_a=2 in EX.
- add $5,$1,$1 then sub $6,$5,$5 -> no stall; fwd_a=fwd_b=1 when sub is in EX.
- add $5,..; nop; or $7,$5,$0 -> fwd_a=2 for or; writes to $0 followed by a $0 read -> fwd 0, no stall.
- ex_br_taken=1 while ID holds a load-use consumer -> ifid_flush=idex_bubble=1, pc_stall=0; next cycle no stall.
- j in ID -> ifid_flush=1 for exactly 1 cycle, pc_stall=0; j in ID with ex_br_taken=1 -> branch wins.
- Assert reset during a stall cycle -> all outputs 0 next edge, scoreboard empty; with PIPE_HAZARD_PERF_EN, 3 stalls plus 2 flushes read 3/2, and the counter saturates at FFFF.
